// File: rtl/clk_enable_gen.sv
// clk_enable_gen: NUM_CH fractional clock-enable streams gated by PLL lock.
// Optional: define CLK_TOGGLE_OUT_EN to add the clk_tgl toggle outputs.
module clk_enable_gen #(
    parameter int NUM_CH      = 3,
    parameter int ACC_W       = 32,
    parameter int LOCK_CYCLES = 1024,
    parameter logic [NUM_CH*ACC_W-1:0] INIT_INC = '0,
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              refclk,
    input  logic              rst_n,
    input  logic              pll_locked,
    input  logic              phase_sync,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [ACC_W-1:0]  cfg_inc,
    output logic              cfg_ready,
    output logic [NUM_CH-1:0] ce_out,
`ifdef CLK_TOGGLE_OUT_EN
    output logic [NUM_CH-1:0] clk_tgl,
`endif
    output logic              locked
);

    localparam int CNT_W = (LOCK_CYCLES > 2) ? $clog2(LOCK_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_WAIT,
        ST_COUNT,
        ST_RUN
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             lk_meta;
    logic             lk_s;
    logic             cfg_acc;
    logic             run_en;
    logic [ACC_W-1:0] inc [NUM_CH];
    logic [ACC_W-1:0] acc [NUM_CH];
    logic [ACC_W:0]   sum [NUM_CH];

    assign cfg_acc = cfg_we & cfg_ready;
    // Stop accumulating as soon as synchronised lock drops, so no
    // pulse escapes into the first cycle outside RUN.
    assign run_en  = (state == ST_RUN) && lk_s;

    // Two-flop synchroniser for the asynchronous PLL lock.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            lk_meta <= 1'b0;
            lk_s    <= 1'b0;
        end else begin
            lk_meta <= pll_locked;
            lk_s    <= lk_meta;
        end
    end

    // Lock qualification FSM with registered locked/cfg_ready.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_WAIT;
            cnt       <= '0;
            locked    <= 1'b0;
            cfg_ready <= 1'b0;
        end else begin
            unique case (state)
                ST_WAIT: begin
                    locked <= 1'b0;
                    if (lk_s) begin
                        state     <= ST_COUNT;
                        cnt       <= '0;
                        cfg_ready <= 1'b1;
                    end else begin
                        cfg_ready <= 1'b0;
                    end
                end
                ST_COUNT: begin
                    if (!lk_s) begin
                        state     <= ST_WAIT;
                        cfg_ready <= 1'b0;
                    end else begin
                        cfg_ready <= !cfg_acc;
                        if (cnt == CNT_W'(LOCK_CYCLES - 1)) begin
                            state  <= ST_RUN;
                            locked <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (!lk_s) begin
                        state     <= ST_WAIT;
                        locked    <= 1'b0;
                        cfg_ready <= 1'b0;
                    end else begin
                        cfg_ready <= !cfg_acc;
                    end
                end
                default: begin
                    state     <= ST_WAIT;
                    locked    <= 1'b0;
                    cfg_ready <= 1'b0;
                end
            endcase
        end
    end

    // Widened sums expose the carry that becomes the enable pulse.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            sum[i] = {1'b0, acc[i]} + {1'b0, inc[i]};
        end
    end

    // Increment registers; out-of-range channel writes match nothing.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                inc[i] <= INIT_INC[i*ACC_W +: ACC_W];
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (cfg_acc && cfg_ch == CH_W'(i)) begin
                    inc[i] <= cfg_inc;
                end
            end
        end
    end

    // Phase accumulators; phase_sync clears them and suppresses carry.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc[i] <= '0;
            end
            ce_out <= '0;
        end else if (run_en && !phase_sync) begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc[i]    <= sum[i][ACC_W-1:0];
                ce_out[i] <= sum[i][ACC_W];
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc[i] <= '0;
            end
            ce_out <= '0;
        end
    end

`ifdef CLK_TOGGLE_OUT_EN
    // Square-wave outputs flip on each enable pulse while running.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            clk_tgl <= '0;
        end else if (state == ST_RUN) begin
            clk_tgl <= clk_tgl ^ ce_out;
        end else begin
            clk_tgl <= '0;
        end
    end
`endif

endmodule
